four_bit_full_subtractor: RTL and testbench
===========================================

// Module: four_bit_full_subtractor
// PURPOSE
//  Registered 4-bit full subtractor: computes diff = a - b - b_in with borrow-out.
//  Arithmetic primitive for ADSR envelope datapaths (level decrement, decay/release steps).
//  Built as a ripple chain of 1-bit full-subtractor cells; result registered once.
// PARAMETERS
//  WIDTH   4   operand/difference width in bits (4 is the only width signed off)
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b, b_in valid this cycle
//  a          in   WIDTH  minuend, unsigned
//  b          in   WIDTH  subtrahend, unsigned
//  b_in       in   1      borrow-in (LSB stage)
//  diff       out  WIDTH  registered difference bits
//  b_out      out  1      registered borrow-out (MSB stage)
//  out_valid  out  1      diff/b_out hold a new result this cycle
// BEHAVIOUR
//  - One clock domain: clk. Asynchronous, active-low reset rst_n.
//  - Combinational core, per bit i (br_0 = b_in):
//      d_i     = a_i ^ b_i ^ br_i
//      br_i+1  = (~a_i & b_i) | (~(a_i ^ b_i) & br_i)
//    b_out = br_WIDTH. Equivalent: {b_out,diff} = {1'b0,a} - {1'b0,b} - b_in, mod 2^(WIDTH+1).
//  - b_out = 1 exactly when a < b + b_in (unsigned); diff then wraps mod 2^WIDTH.
//  - Latency: 1 cycle. On a rising clk edge with in_valid=1, diff/b_out load the core
//    result and out_valid=1 the following cycle.
//  - On a rising clk edge with in_valid=0: diff/b_out hold their previous values;
//    out_valid=0.
//  - No backpressure; a new operand set is accepted every cycle (throughput 1/clk).
//  - Reset (rst_n=0, asynchronous, any time incl. mid-stream): diff=0, b_out=0,
//    out_valid=0 immediately. Operation resumes on the first rising edge after
//    rst_n deasserts. In-flight results are discarded.
//  - X/Z on a, b, b_in with in_valid=0 does not disturb outputs.
//  - No internal state besides the output registers and out_valid.
// TESTING
//  1. Exhaustive: b_in in {0,1}, {b,a} = 0..255, in_valid=1 each cycle ->
//     one cycle later {b_out,diff} == ({1'b0,a}-{1'b0,b}-b_in) & 5'h1F (512 checks).
//  2. a=5,b=3,b_in=0 -> diff=2, b_out=0; a=3,b=5,b_in=0 -> diff=4'hE, b_out=1.
//  3. Borrow-in corners: a=0,b=0,b_in=1 -> diff=4'hF,b_out=1; a=F,b=F,b_in=1 ->
//     diff=4'hF,b_out=1; a=F,b=0,b_in=1 -> diff=4'hE,b_out=0.
//  4. Hold: load a=9,b=2,b_in=0 (diff=7), then in_valid=0 with a=1,b=8 for 3 cycles ->
//     diff stays 7, b_out stays 0, out_valid=0.
//  5. Reset mid-stream: assert rst_n=0 between edges after loading a=3,b=5 ->
//     diff=0, b_out=0, out_valid=0 before next edge; first valid input after
//     release produces correct result one cycle later.
//  6. Back-to-back: alternate (a=8,b=1,b_in=1)/(a=1,b=8,b_in=0) every cycle ->
//     outputs alternate diff=6,b_out=0 / diff=9,b_out=1, out_valid held 1.

Source files
------------

// File: rtl/four_bit_full_subtractor_if.sv
// Operand/result bundle for the registered ripple subtractor.
//
// Handshake: in_valid qualifies a, b and b_in in the cycle it is high.
// The block has no ready signal because it accepts a new operand set
// every cycle. out_valid is high for exactly one cycle per accepted
// operand set, one cycle after acceptance. diff and b_out keep their
// last loaded value while out_valid is low.
interface four_bit_full_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             out_valid;

  // The master drives operands and observes results.
  modport master (
    output in_valid, a, b, b_in,
    input  diff, b_out, out_valid
  );

  // The subtractor consumes operands and produces results.
  modport slave (
    input  in_valid, a, b, b_in,
    output diff, b_out, out_valid
  );
endinterface

// File: rtl/four_bit_full_subtractor.sv
// Registered 4-bit full subtractor: {b_out, diff} = a - b - b_in.
// The core is a ripple chain of 1-bit full-subtractor cells. Borrow enters
// at the LSB and leaves at the MSB. The result is registered once. The
// output registers load only on accepted operands, so garbage on the
// operand lines while in_valid is low never reaches diff/b_out.
module four_bit_full_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  four_bit_full_subtractor_if.slave   sub
);

  // Borrow chain: br[0] is the borrow-in, br[WIDTH] is the borrow-out.
  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d_core;

  assign br[0] = sub.b_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    // Difference bit and borrow to the next more significant stage.
    assign d_core[i] = sub.a[i] ^ sub.b[i] ^ br[i];
    assign br[i+1]   = (~sub.a[i] & sub.b[i]) | (~(sub.a[i] ^ sub.b[i]) & br[i]);
  end

  // Result registers load on accepted operands and otherwise hold.
  // out_valid marks the cycle after each accepted operand set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub.diff      <= '0;
      sub.b_out     <= 1'b0;
      sub.out_valid <= 1'b0;
    end else begin
      sub.out_valid <= sub.in_valid;
      if (sub.in_valid) begin
        sub.diff  <= d_core;
        sub.b_out <= br[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_four_bit_full_subtractor.sv
// Self-checking bench for four_bit_full_subtractor: reset, exhaustive sweep,
// directed corners, hold, mid-stream reset, back-to-back and random traffic.
module tb_four_bit_full_subtractor;

  localparam int WIDTH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  four_bit_full_subtractor_if #(.WIDTH(WIDTH)) bus ();

  four_bit_full_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] held;
  int n_total;
  int n_pass;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: plain integer subtraction wrapped into WIDTH+1 bits.
  // The top bit of the wrapped value is the borrow-out.
  function automatic logic [WIDTH:0] model(input int ma, input int mb, input int mbin);
    int r;
    r = ma - mb - mbin;
    if (r < 0) r = r + (1 << (WIDTH + 1));
    return r[WIDTH:0];
  endfunction

  // ---------------- driver ----------------
  // Present one operand set, let one edge pass, then check the registered
  // result against the scoreboard. When in_valid is low, the check uses the held value.
  task automatic apply(input bit v, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input bit tbin);
    bus.in_valid = v;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.b_in     = tbin;
    if (v) exp_q.push_back(model(int'(ta), int'(tb_v), int'(tbin)));
    @(posedge clk);
    #1;
    if (v) held = exp_q.pop_front();
    check("result", {bus.b_out, bus.diff}, held);
    check("out_valid", bus.out_valid, v);
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               bin;
    logic [WIDTH-1:0] ediff;
    bit               ebout;
  } dir_t;

  dir_t dir_tab[5];

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0;
    n_pass  = 0;
    held    = '0;
    rst_n   = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.b_in = 1'b0;

    // Reset state
    #1;
    check("rst_diff", bus.diff, 0);
    check("rst_b_out", bus.b_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep, valid every cycle
    for (int bi = 0; bi < 2; bi++) begin
      for (int ab = 0; ab < 256; ab++) begin
        logic [7:0] abv;
        abv = ab[7:0];
        apply(1'b1, abv[3:0], abv[7:4], bi[0]);
      end
    end

    // Directed values with literal expectations
    dir_tab[0] = '{4'd5, 4'd3, 1'b0, 4'h2, 1'b0};
    dir_tab[1] = '{4'd3, 4'd5, 1'b0, 4'hE, 1'b1};
    dir_tab[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    dir_tab[3] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    dir_tab[4] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, dir_tab[i].a, dir_tab[i].b, dir_tab[i].bin);
      check("dir_diff", bus.diff, dir_tab[i].ediff);
      check("dir_b_out", bus.b_out, dir_tab[i].ebout);
    end

    // Hold while in_valid is low
    apply(1'b1, 4'd9, 4'd2, 1'b0);
    check("hold_load", bus.diff, 7);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'd1, 4'd8, 1'b0);
      check("hold_diff", bus.diff, 7);
      check("hold_b_out", bus.b_out, 0);
    end

    // Mid-stream reset between edges
    apply(1'b1, 4'd3, 4'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_diff", bus.diff, 0);
    check("mid_rst_b_out", bus.b_out, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    held = '0;
    exp_q.delete();
    apply(1'b1, 4'd12, 4'd4, 1'b1);
    check("post_rst_diff", bus.diff, 7);

    // Back-to-back alternating operand sets
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        apply(1'b1, 4'd8, 4'd1, 1'b1);
        check("b2b_diff", bus.diff, 6);
        check("b2b_b_out", bus.b_out, 0);
      end else begin
        apply(1'b1, 4'd1, 4'd8, 1'b0);
        check("b2b_diff", bus.diff, 9);
        check("b2b_b_out", bus.b_out, 1);
      end
    end

    // Random traffic with random gaps; operands are garbage while idle
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog in case time stops advancing
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
